cmip_cnt_win_ctrl: RTL and testbench

//  Windowed statistics controller for the Aurora link event counters. Runs NUM_CH saturating
//  per-channel event counters over a programmable window of win_len clk cycles, snapshots all

---
 rtl/cmip_cnt_win_ctrl.sv | 136 +++++++++++++
 tb/tb_cmip_cnt_win_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmip_cnt_win_ctrl.sv
// Windowed per-channel saturating event counters: snapshot at window end, then stream the
// snapshot out one channel per valid/ready beat; a snapshot arriving mid-dump is dropped and flagged.
module cmip_cnt_win_ctrl #(
    parameter int NUM_CH = 4,
    parameter int width  = 16,
    parameter int WIN_W  = 24,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WIN_W-1:0]  win_len,
    input  logic [NUM_CH-1:0] evt,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [CH_W-1:0]   out_ch,
    output logic [width-1:0]  out_cnt,
    output logic              out_last,
    output logic              busy,
    output logic              ovr,
    input  logic              ovr_clr
);

    typedef enum logic {W_IDLE, W_RUN}  win_state_t;
    typedef enum logic {D_IDLE, D_SEND} dump_state_t;

    win_state_t  win_q, win_d;
    dump_state_t dump_q, dump_d;

    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] timer;
    logic [width-1:0] cnt     [NUM_CH];
    logic [width-1:0] cnt_inc [NUM_CH];
    logic [width-1:0] shadow  [NUM_CH];
    logic [CH_W-1:0]  ch_nxt;
    logic             win_end;
    logic             dump_start;
    logic             drop;
    logic             xfer;

    function automatic logic [width-1:0] sat_inc(input logic [width-1:0] c, input logic e);
        return (e && !(&c)) ? c + width'(1) : c;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_inc[i] = sat_inc(cnt[i], evt[i]);
        end
    end

    assign win_end    = (win_q == W_RUN) && (timer == win_len_q - WIN_W'(1));
    assign dump_start = win_end && (dump_q == D_IDLE);
    assign drop       = win_end && (dump_q != D_IDLE);
    assign xfer       = out_vld && out_rdy;
    assign ch_nxt     = out_ch + CH_W'(1);

    always_comb begin
        win_d = win_q;
        case (win_q)
            W_IDLE:  if (en)  win_d = W_RUN;
            W_RUN:   if (!en) win_d = W_IDLE;
            default: win_d = W_IDLE;
        endcase
    end

    always_comb begin
        dump_d = dump_q;
        case (dump_q)
            D_IDLE:  if (dump_start)       dump_d = D_SEND;
            D_SEND:  if (xfer && out_last) dump_d = D_IDLE;
            default: dump_d = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q  <= W_IDLE;
            dump_q <= D_IDLE;
        end else begin
            win_q  <= win_d;
            dump_q <= dump_d;
        end
    end

    // Window timer and live counters; a zero length is treated as a 1-cycle window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_len_q <= '0;
            timer     <= '0;
            busy      <= 1'b0;
            ovr       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else begin
            busy <= (win_d == W_RUN);
            ovr  <= drop || (ovr && !ovr_clr);
            if (win_q == W_IDLE) begin
                if (en) begin
                    win_len_q <= (win_len == '0) ? WIN_W'(1) : win_len;
                    timer     <= '0;
                    for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
                end
            end else begin
                timer <= win_end ? '0 : timer + WIN_W'(1);
                for (int i = 0; i < NUM_CH; i++) cnt[i] <= win_end ? '0 : cnt_inc[i];
            end
        end
    end

    // Snapshot capture and beat sequencing; first beat is preloaded so out_cnt is registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_ch   <= '0;
            out_cnt  <= '0;
            out_last <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
        end else if (dump_start) begin
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= cnt_inc[i];
            out_vld  <= 1'b1;
            out_ch   <= '0;
            out_cnt  <= cnt_inc[0];
            out_last <= 1'b0;
        end else if (xfer) begin
            if (out_last) begin
                out_vld  <= 1'b0;
                out_ch   <= '0;
                out_last <= 1'b0;
            end else begin
                out_ch   <= ch_nxt;
                out_cnt  <= shadow[ch_nxt];
                out_last <= (ch_nxt == CH_W'(NUM_CH - 1));
            end
        end
    end

endmodule

// File: tb/tb_cmip_cnt_win_ctrl.sv
// Bench for cmip_cnt_win_ctrl: directed scenarios plus randomized traffic, each cycle compared
// against a window/snapshot-queue reference model.
module tb_cmip_cnt_win_ctrl;

    localparam int NCH  = 4;
    localparam int MAXV = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [23:0] win_len;
    logic [3:0]  evt;
    logic        out_vld;
    logic        out_rdy;
    logic [1:0]  out_ch;
    logic [7:0]  out_cnt;
    logic        out_last;
    logic        busy;
    logic        ovr;
    logic        ovr_clr;

    int tests  = 0;
    int failed = 0;

    cmip_cnt_win_ctrl #(.NUM_CH(4), .width(8), .WIN_W(24), .CH_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .win_len(win_len), .evt(evt),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_ch(out_ch), .out_cnt(out_cnt),
        .out_last(out_last), .busy(busy), .ovr(ovr), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    // Reference model: window bookkeeping plus a queue of pending snapshot beats.
    bit m_run, m_vld, m_ovr;
    int m_len, m_t;
    int m_cnt[NCH];
    int q_ch[$];
    int q_cnt[$];
    logic [10:0] bt[$];

    function automatic void model_update();
        bit xfer, wend, take;
        int v;
        if (!rst_n) begin
            m_run = 0; m_vld = 0; m_ovr = 0; m_t = 0; m_len = 0;
            for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
            q_ch.delete(); q_cnt.delete();
            return;
        end
        xfer = m_vld && out_rdy;
        wend = m_run && (m_t == m_len - 1);
        take = wend && !m_vld;
        m_ovr = (wend && m_vld) || (m_ovr && !ovr_clr);
        if (xfer) begin
            void'(q_ch.pop_front());
            void'(q_cnt.pop_front());
            if (q_ch.size() == 0) m_vld = 0;
        end
        if (m_run) begin
            for (int i = 0; i < NCH; i++) begin
                v = m_cnt[i] + int'(evt[i]);
                if (v > MAXV) v = MAXV;
                if (take) begin q_ch.push_back(i); q_cnt.push_back(v); end
                m_cnt[i] = wend ? 0 : v;
            end
            m_t = wend ? 0 : m_t + 1;
            if (!en) m_run = 0;
        end else if (en) begin
            m_run = 1;
            m_len = (win_len == 0) ? 1 : int'(win_len);
            m_t = 0;
            for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
        end
        if (take) m_vld = 1;
    endfunction

    function automatic logic [13:0] exp_vec();
        logic [1:0] c = 2'b0;
        logic [7:0] v = 8'b0;
        logic       l = 1'b0;
        if (m_vld) begin
            c = 2'(q_ch[0]);
            v = 8'(q_cnt[0]);
            l = (q_ch[0] == NCH - 1);
        end
        return {m_vld, c, v, l, m_run, m_ovr};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {out_vld, out_vld ? out_ch : 2'b0, out_vld ? out_cnt : 8'b0,
                out_vld ? out_last : 1'b0, busy, ovr};
    endfunction

    function automatic logic [10:0] beat(input int i);
        return (i < bt.size()) ? bt[i] : 11'bx;
    endfunction

    task automatic step();
        if (out_vld === 1'b1 && out_rdy === 1'b1 && rst_n === 1'b1)
            bt.push_back({out_last, out_ch, out_cnt});
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        en = 0; evt = 0; out_rdy = 1; ovr_clr = 1;
        repeat (n) step();
        ovr_clr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; en = 0; evt = 0; out_rdy = 0; ovr_clr = 0; win_len = 0;
        repeat (3) step();
        tests++;
        if ({out_vld, out_ch, out_cnt, out_last, busy, ovr} !== 14'd0) begin
            failed++;
            $display("FAIL reset_outputs got %h exp 0", {out_vld, out_ch, out_cnt, out_last, busy, ovr});
        end
        tests++;
        if (obs_vec() !== exp_vec()) begin
            failed++; $display("FAIL reset_model got %h exp %h", obs_vec(), exp_vec());
        end
        rst_n = 1;
        step();
    endtask

    task automatic test_basic();
        int first = -1;
        logic [10:0] exp_b[4] = '{{1'b0, 2'd0, 8'd10}, {1'b0, 2'd1, 8'd5},
                                  {1'b0, 2'd2, 8'd0}, {1'b1, 2'd3, 8'd0}};
        bt.delete();
        for (int k = 0; k <= 16; k++) begin
            en = 1; win_len = 10; out_rdy = 1; ovr_clr = 0;
            evt = {2'b00, 1'(k % 2 == 1), 1'b1};
            step();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                failed++; $display("FAIL basic_model cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
            end
            if (first < 0 && out_vld === 1'b1) first = k;
        end
        tests++;
        if (first != 10) begin failed++; $display("FAIL basic_first_vld got %0d exp 10", first); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (beat(i) !== exp_b[i]) begin
                failed++; $display("FAIL basic_beat%0d got %h exp %h", i, beat(i), exp_b[i]);
            end
        end
        tests++;
        if (ovr !== 1'b0) begin failed++; $display("FAIL basic_ovr got %b exp 0", ovr); end
        idle(12);
    endtask

    task automatic test_saturation();
        bt.delete();
        for (int k = 0; k <= 610; k++) begin
            en = 1; win_len = 300; out_rdy = 1; ovr_clr = 0;
            evt = (k <= 320) ? 4'b0100 : 4'b0000;
            step();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                failed++; $display("FAIL sat_model cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
            end
        end
        tests++;
        if (beat(2) !== {1'b0, 2'd2, 8'd255}) begin
            failed++; $display("FAIL sat_win1_ch2 got %h exp %h", beat(2), {1'b0, 2'd2, 8'd255});
        end
        tests++;
        if (beat(6) !== {1'b0, 2'd2, 8'd20}) begin
            failed++; $display("FAIL sat_win2_ch2 got %h exp %h", beat(6), {1'b0, 2'd2, 8'd20});
        end
        idle(12);
    endtask

    task automatic test_backpressure();
        int sum1[NCH] = '{0, 0, 0, 0};
        bt.delete();
        for (int k = 0; k <= 45; k++) begin
            en = 1; win_len = 8; evt = 4'($urandom);
            out_rdy = (k >= 9 && k <= 28) ? 1'b0 : 1'b1;
            ovr_clr = (k == 24);
            if (k >= 1 && k <= 8)
                for (int i = 0; i < NCH; i++) sum1[i] += int'(evt[i]);
            step();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                failed++; $display("FAIL bp_model cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
            end
            if (k >= 9 && k <= 28) begin
                tests++;
                if ({out_vld, out_ch, out_cnt} !== {1'b1, 2'd0, 8'(sum1[0])}) begin
                    failed++;
                    $display("FAIL bp_stable cyc %0d got %h exp %h", k, {out_vld, out_ch, out_cnt},
                             {1'b1, 2'd0, 8'(sum1[0])});
                end
            end
            if (k == 15 || k == 16 || k == 24) begin
                tests++;
                if (ovr !== (k != 15)) begin
                    failed++; $display("FAIL bp_ovr cyc %0d got %b exp %b", k, ovr, k != 15);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (beat(i) !== {1'(i == 3), 2'(i), 8'(sum1[i])}) begin
                failed++;
                $display("FAIL bp_beat%0d got %h exp %h", i, beat(i), {1'(i == 3), 2'(i), 8'(sum1[i])});
            end
        end
        idle(12);
    endtask

    task automatic test_boundary();
        logic [10:0] exp_b[8] = '{{1'b0, 2'd0, 8'd0}, {1'b0, 2'd1, 8'd0}, {1'b0, 2'd2, 8'd0},
                                  {1'b1, 2'd3, 8'd1}, {1'b0, 2'd0, 8'd0}, {1'b0, 2'd1, 8'd0},
                                  {1'b0, 2'd2, 8'd1}, {1'b1, 2'd3, 8'd1}};
        bt.delete();
        for (int k = 0; k <= 17; k++) begin
            en = 1; win_len = 4; out_rdy = 1; ovr_clr = 0;
            evt = (k == 4 || k == 12 || k == 13) ? 4'b1000 :
                  (k == 8) ? 4'b0010 : (k == 9) ? 4'b0100 : 4'b0000;
            step();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                failed++; $display("FAIL bnd_model cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
            end
            if (k == 7 || k == 8) begin
                tests++;
                if (ovr !== (k == 8)) begin
                    failed++; $display("FAIL bnd_ovr cyc %0d got %b exp %b", k, ovr, k == 8);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (beat(i) !== exp_b[i]) begin
                failed++; $display("FAIL bnd_beat%0d got %h exp %h", i, beat(i), exp_b[i]);
            end
        end
        idle(12);
        bt.delete();
        for (int k = 0; k <= 7; k++) begin
            en = 1; win_len = 0; out_rdy = 1; ovr_clr = 0; evt = 4'hF;
            step();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                failed++; $display("FAIL len0_model cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
            end
            if (k == 1 || k == 2) begin
                tests++;
                if (ovr !== (k == 2)) begin
                    failed++; $display("FAIL len0_ovr cyc %0d got %b exp %b", k, ovr, k == 2);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (beat(i) !== {1'(i == 3), 2'(i), 8'd1}) begin
                failed++; $display("FAIL len0_beat%0d got %h exp %h", i, beat(i), {1'(i == 3), 2'(i), 8'd1});
            end
        end
        idle(12);
    endtask

    task automatic test_en_drop();
        bt.delete();
        for (int k = 0; k <= 31; k++) begin
            en = !(k >= 9 && k <= 19); win_len = 6; ovr_clr = 0;
            out_rdy = (k >= 7 && k <= 9) ? 1'b0 : 1'b1;
            evt = (k >= 7 && k <= 9) ? 4'b0010 : (k >= 20) ? 4'b0001 : 4'b0000;
            step();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                failed++; $display("FAIL endrop_model cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
            end
            if (k >= 9 && k <= 19) begin
                tests++;
                if (busy !== 1'b0 || (k >= 14 && out_vld !== 1'b0)) begin
                    failed++; $display("FAIL endrop_idle cyc %0d got busy=%b vld=%b exp 0", k, busy, out_vld);
                end
            end
        end
        tests++;
        if (bt.size() != 8) begin failed++; $display("FAIL endrop_nbeats got %0d exp 8", bt.size()); end
        tests++;
        if (beat(3) !== {1'b1, 2'd3, 8'd0}) begin
            failed++; $display("FAIL endrop_dump1_last got %h exp %h", beat(3), {1'b1, 2'd3, 8'd0});
        end
        tests++;
        if ({beat(4), beat(5)} !== {1'b0, 2'd0, 8'd6, 1'b0, 2'd1, 8'd0}) begin
            failed++;
            $display("FAIL endrop_restart got %h exp %h", {beat(4), beat(5)}, {1'b0, 2'd0, 8'd6, 1'b0, 2'd1, 8'd0});
        end
        idle(12);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k <= 11; k++) begin
            en = 1; win_len = 5; out_rdy = 0; ovr_clr = 0; evt = 4'($urandom);
            step();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                failed++; $display("FAIL rstmid_model cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
            end
        end
        tests++;
        if ({out_vld, ovr, busy} !== 3'b111) begin
            failed++; $display("FAIL rstmid_pre got %b exp 111", {out_vld, ovr, busy});
        end
        rst_n = 0;
        step();
        tests++;
        if ({out_vld, ovr, busy, out_ch} !== 5'd0) begin
            failed++; $display("FAIL rstmid_post got %b exp 00000", {out_vld, ovr, busy, out_ch});
        end
        rst_n = 1; en = 0; out_rdy = 1;
        for (int k = 0; k < 10; k++) begin
            evt = 4'($urandom);
            step();
            tests++;
            if ({out_vld, busy} !== 2'b00 || obs_vec() !== exp_vec()) begin
                failed++; $display("FAIL rstmid_quiet cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
            end
        end
        en = 1; win_len = 3;
        step();
        tests++;
        if (busy !== 1'b1) begin failed++; $display("FAIL rstmid_restart got busy=%b exp 1", busy); end
        idle(12);
    endtask

    task automatic test_back_to_back();
        logic en_r = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 63) == 0) en_r = !en_r;
            en = en_r;
            win_len = 24'($urandom_range(0, 12));
            evt = 4'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            ovr_clr = ($urandom_range(0, 15) == 0);
            step();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                failed++; $display("FAIL b2b_model cyc %0d got %h exp %h", k, obs_vec(), exp_vec());
            end
        end
        idle(12);
    endtask

    initial begin
        rst_n = 0; en = 0; win_len = 0; evt = 0; out_rdy = 0; ovr_clr = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_boundary();
        test_en_drop();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
